// File: rtl/seq_detector_pkg.sv
// Package: seq_detector_pkg
// Purpose : Shared constants for the parametrised Moore serial-pattern detector.
//           Holds the default geometry (pattern width, reset pattern, counter
//           width) and the encoding of the overlap-mode select input.
// Ports   : none (package)
package seq_detector_pkg;

    localparam int         DEFAULT_PAT_W   = 3;
    localparam logic [2:0] DEFAULT_PATTERN = 3'b101;
    localparam int         DEFAULT_CNT_W   = 8;

    // Encoding of the overlap select input
    localparam logic MODE_NONOVERLAP = 1'b0;
    localparam logic MODE_OVERLAP    = 1'b1;

endpackage : seq_detector_pkg

// File: rtl/seq_detector_moore_param_if.sv
// Interface: seq_detector_moore_param_if
// Purpose  : Groups the serial-line control/data signals and the detector
//            results so that the detector and its driver share one bundle.
// Signals  : en        - sample x on this edge
//            x         - serial input bit
//            overlap   - 1 = overlapping detection, 0 = restart after a match
//            pat_load  - load pat_in into the pattern register this edge
//            pat_in    - new pattern, MSB = first bit received
//            y         - registered Moore match flag
//            match_cnt - saturating detection count (0 when counter not built)
// Modports : master drives the controls, slave is the detector.
interface seq_detector_moore_param_if #(
    parameter int PAT_W = 3,
    parameter int CNT_W = 8
);

    logic             en;
    logic             x;
    logic             overlap;
    logic             pat_load;
    logic [PAT_W-1:0] pat_in;
    logic             y;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output en, x, overlap, pat_load, pat_in,
        input  y, match_cnt
    );

    modport slave (
        input  en, x, overlap, pat_load, pat_in,
        output y, match_cnt
    );

endinterface : seq_detector_moore_param_if

// File: rtl/seq_sat_counter.sv
// Module : seq_sat_counter
// Purpose: Saturating up-counter with synchronous clear. Counts inc pulses
//          and sticks at all-ones; clr has priority over inc.
// Ports  : clk_i  - rising-edge clock
//          rst_ni - asynchronous reset, active-low
//          inc_i  - increment request
//          clr_i  - synchronous clear
//          cnt_o  - registered count value
module seq_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next-count logic: clear first, then saturating increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule : seq_sat_counter

// File: rtl/seq_detector_moore_param.sv
// Module : seq_detector_moore_param
// Purpose: Parametrised Moore serial-pattern detector. Shifts the serial bit
//          x into a history register on every enabled edge and flags y when
//          the last PAT_W bits equal a run-time programmable pattern.
//          Overlapping or non-overlapping detection is selected per edge.
// Ports  : clk - rising-edge clock
//          rst - asynchronous reset, active-low
//          bus - seq_detector_moore_param_if.slave (en, x, overlap,
//                pat_load, pat_in in; y, match_cnt out)
// Config : macro SEQ_DETECTOR_MATCH_CNT_EN builds the saturating match
//          counter; without it match_cnt is tied to zero.
module seq_detector_moore_param
    import seq_detector_pkg::*;
#(
    parameter int               PAT_W   = DEFAULT_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEFAULT_PATTERN,
    parameter int               CNT_W   = DEFAULT_CNT_W
) (
    input  logic                       clk,
    input  logic                       rst,
    seq_detector_moore_param_if.slave  bus
);

    // fill counts valid history bits 0..PAT_W
    localparam int               FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);

    logic [PAT_W-1:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [PAT_W-1:0]  pat_q,  pat_d;
    logic              y_q,    y_d;

    // Next-state logic; y is decoded from the next state so the registered
    // flag always equals (fill==PAT_W && hist==pattern) of the stored state.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        pat_d  = pat_q;
        if (bus.pat_load) begin
            // Loading a pattern wins over en and discards this edge's bit
            pat_d  = bus.pat_in;
            hist_d = {PAT_W{1'b0}};
            fill_d = {FILL_W{1'b0}};
        end else if (bus.en) begin
            hist_d = {hist_q[PAT_W-2:0], bus.x};
            if (y_q && (bus.overlap != MODE_OVERLAP)) begin
                // Non-overlapping: the bit after a match starts a fresh window
                fill_d = FILL_ONE;
            end else if (fill_q != FILL_FULL) begin
                fill_d = fill_q + FILL_ONE;
            end else begin
                fill_d = fill_q;
            end
        end else begin
            hist_d = hist_q;
            fill_d = fill_q;
            pat_d  = pat_q;
        end
        y_d = (fill_d == FILL_FULL) && (hist_d == pat_d);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= {PAT_W{1'b0}};
            fill_q <= {FILL_W{1'b0}};
            pat_q  <= PATTERN;
            y_q    <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
            y_q    <= y_d;
        end
    end

    assign bus.y = y_q;

`ifdef SEQ_DETECTOR_MATCH_CNT_EN
    // Count only sampling edges that produce a match; held edges do not count
    logic cnt_inc_s;
    assign cnt_inc_s = bus.en && !bus.pat_load && y_d;

    seq_sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk_i  (clk),
        .rst_ni (rst),
        .inc_i  (cnt_inc_s),
        .clr_i  (bus.pat_load),
        .cnt_o  (bus.match_cnt)
    );
`else
    assign bus.match_cnt = {CNT_W{1'b0}};
`endif

endmodule : seq_detector_moore_param

// File: tb/tb_seq_detector_moore_param.sv
// Testbench: tb_seq_detector_moore_param
// Purpose  : Directed, self-checking bench for seq_detector_moore_param.
//            dut3 uses the default 3-bit "101" geometry; dut4 uses a 4-bit
//            "1111" pattern with a 2-bit counter to exercise saturation.
//            Expected counts follow SEQ_DETECTOR_MATCH_CNT_EN.
module tb_seq_detector_moore_param;

`ifdef SEQ_DETECTOR_MATCH_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    seq_detector_moore_param_if #(.PAT_W(3), .CNT_W(8)) bus3 ();
    seq_detector_moore_param_if #(.PAT_W(4), .CNT_W(2)) bus4 ();

    seq_detector_moore_param #(
        .PAT_W   (3),
        .PATTERN (3'b101),
        .CNT_W   (8)
    ) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    seq_detector_moore_param #(
        .PAT_W   (4),
        .PATTERN (4'b1111),
        .CNT_W   (2)
    ) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one edge on dut3 and settle 1 time unit after it
    task automatic step3(input logic en, input logic xb, input logic ld);
        bus3.en       = en;
        bus3.x        = xb;
        bus3.pat_load = ld;
        @(posedge clk);
        #1;
        bus3.pat_load = 1'b0;
    endtask

    task automatic step4(input logic en, input logic xb);
        bus4.en = en;
        bus4.x  = xb;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        bus3.en = 1'b0; bus3.pat_load = 1'b0;
        bus4.en = 1'b0; bus4.pat_load = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus3.en = 1'b1; bus3.x = i[0]; bus3.overlap = 1'b1;
            bus4.en = 1'b1; bus4.x = 1'b1; bus4.overlap = 1'b1;
            @(posedge clk);
            #1;
            checks++;
            if (bus3.y !== 1'b0 || bus3.match_cnt !== 8'd0) begin
                errors++;
                $display("FAIL reset_hold3[%0d]: got y=%0b cnt=%0d, expected y=0 cnt=0", i, bus3.y, bus3.match_cnt);
            end
            checks++;
            if (bus4.y !== 1'b0 || bus4.match_cnt !== 2'd0) begin
                errors++;
                $display("FAIL reset_hold4[%0d]: got y=%0b cnt=%0d, expected y=0 cnt=0", i, bus4.y, bus4.match_cnt);
            end
        end
        bus4.en = 1'b0;
        rst = 1'b1;
        // Reset pattern must be 101 and history must start empty
        begin
            logic [2:0] xs;
            logic [2:0] ey;
            xs = 3'b101;
            ey = 3'b001;
            for (int i = 0; i < 3; i++) begin
                step3(1'b1, xs[2-i], 1'b0);
                checks++;
                if (bus3.y !== ey[2-i]) begin
                    errors++;
                    $display("FAIL reset_restart[%0d]: got y=%0b, expected %0b", i, bus3.y, ey[2-i]);
                end
            end
        end
    endtask

    task automatic test_overlap();
        logic [4:0] xs;
        logic [4:0] ey;
        int         ec[5];
        apply_reset();
        bus3.overlap = 1'b1;
        xs = 5'b10101;
        ey = 5'b00101;
        ec = '{0, 0, 1, 1, 2};
        for (int i = 0; i < 5; i++) begin
            step3(1'b1, xs[4-i], 1'b0);
            checks++;
            if (bus3.y !== ey[4-i] || bus3.match_cnt !== 8'(CNT_EN ? ec[i] : 0)) begin
                errors++;
                $display("FAIL overlap[%0d]: got y=%0b cnt=%0d, expected y=%0b cnt=%0d", i, bus3.y, bus3.match_cnt, ey[4-i], CNT_EN ? ec[i] : 0);
            end
        end
    endtask

    task automatic test_nonoverlap();
        logic [7:0] xs;
        logic [7:0] ey;
        int         ec[8];
        apply_reset();
        bus3.overlap = 1'b0;
        xs = 8'b10101101;
        ey = 8'b00100001;
        ec = '{0, 0, 1, 1, 1, 1, 1, 2};
        for (int i = 0; i < 8; i++) begin
            step3(1'b1, xs[7-i], 1'b0);
            checks++;
            if (bus3.y !== ey[7-i] || bus3.match_cnt !== 8'(CNT_EN ? ec[i] : 0)) begin
                errors++;
                $display("FAIL nonoverlap[%0d]: got y=%0b cnt=%0d, expected y=%0b cnt=%0d", i, bus3.y, bus3.match_cnt, ey[7-i], CNT_EN ? ec[i] : 0);
            end
        end
    endtask

    task automatic test_enable_hold();
        apply_reset();
        bus3.overlap = 1'b1;
        step3(1'b1, 1'b1, 1'b0);
        step3(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step3(1'b0, i[0], 1'b0);
            checks++;
            if (bus3.y !== 1'b0) begin
                errors++;
                $display("FAIL en_hold_idle[%0d]: got y=%0b, expected 0", i, bus3.y);
            end
        end
        step3(1'b1, 1'b1, 1'b0);
        checks++;
        if (bus3.y !== 1'b1) begin
            errors++;
            $display("FAIL en_hold_match: got y=%0b, expected 1", bus3.y);
        end
        for (int i = 0; i < 2; i++) begin
            step3(1'b0, 1'b0, 1'b0);
            checks++;
            if (bus3.y !== 1'b1 || bus3.match_cnt !== 8'(CNT_EN ? 1 : 0)) begin
                errors++;
                $display("FAIL en_hold_high[%0d]: got y=%0b cnt=%0d, expected y=1 cnt=%0d", i, bus3.y, bus3.match_cnt, CNT_EN ? 1 : 0);
            end
        end
        step3(1'b1, 1'b0, 1'b0);
        checks++;
        if (bus3.y !== 1'b0) begin
            errors++;
            $display("FAIL en_hold_release: got y=%0b, expected 0", bus3.y);
        end
    endtask

    task automatic test_pat_load();
        logic [4:0] xs;
        logic [4:0] ey;
        apply_reset();
        bus3.overlap = 1'b1;
        step3(1'b1, 1'b1, 1'b0);
        step3(1'b1, 1'b0, 1'b0);
        step3(1'b1, 1'b1, 1'b0);
        checks++;
        if (bus3.y !== 1'b1 || bus3.match_cnt !== 8'(CNT_EN ? 1 : 0)) begin
            errors++;
            $display("FAIL pat_load_pre: got y=%0b cnt=%0d, expected y=1 cnt=%0d", bus3.y, bus3.match_cnt, CNT_EN ? 1 : 0);
        end
        bus3.pat_in = 3'b110;
        step3(1'b1, 1'b1, 1'b1);
        checks++;
        if (bus3.y !== 1'b0 || bus3.match_cnt !== 8'd0) begin
            errors++;
            $display("FAIL pat_load_edge: got y=%0b cnt=%0d, expected y=0 cnt=0", bus3.y, bus3.match_cnt);
        end
        // A kept load-edge bit would make 1,0 complete 110 early
        xs = 5'b10110;
        ey = 5'b00001;
        for (int i = 0; i < 5; i++) begin
            step3(1'b1, xs[4-i], 1'b0);
            checks++;
            if (bus3.y !== ey[4-i]) begin
                errors++;
                $display("FAIL pat_load_stream[%0d]: got y=%0b, expected %0b", i, bus3.y, ey[4-i]);
            end
        end
    endtask

    task automatic test_mode_switch();
        logic [7:0] ey;
        apply_reset();
        bus3.overlap = 1'b0;
        bus3.pat_in  = 3'b111;
        step3(1'b1, 1'b0, 1'b1);
        ey = 8'b00100111;
        for (int i = 0; i < 8; i++) begin
            if (i == 6) bus3.overlap = 1'b1;
            step3(1'b1, 1'b1, 1'b0);
            checks++;
            if (bus3.y !== ey[7-i]) begin
                errors++;
                $display("FAIL mode_switch[%0d]: got y=%0b, expected %0b", i, bus3.y, ey[7-i]);
            end
        end
    endtask

    task automatic test_back_to_back_ones();
        logic [7:0] xs;
        logic [7:0] ey;
        int         ec[8];
        apply_reset();
        bus4.overlap = 1'b1;
        bus4.pat_load = 1'b0;
        xs = 8'b11111110;
        ey = 8'b00011110;
        ec = '{0, 0, 0, 1, 2, 3, 3, 3};
        for (int i = 0; i < 8; i++) begin
            step4(1'b1, xs[7-i]);
            checks++;
            if (bus4.y !== ey[7-i] || bus4.match_cnt !== 2'(CNT_EN ? ec[i] : 0)) begin
                errors++;
                $display("FAIL ones4[%0d]: got y=%0b cnt=%0d, expected y=%0b cnt=%0d", i, bus4.y, bus4.match_cnt, ey[7-i], CNT_EN ? ec[i] : 0);
            end
        end
        bus4.en = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus3.en = 1'b0; bus3.x = 1'b0; bus3.overlap = 1'b1; bus3.pat_load = 1'b0; bus3.pat_in = 3'b000;
        bus4.en = 1'b0; bus4.x = 1'b0; bus4.overlap = 1'b1; bus4.pat_load = 1'b0; bus4.pat_in = 4'b0000;
        #2;
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_enable_hold();
        test_pat_load();
        test_mode_switch();
        test_back_to_back_ones();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_seq_detector_moore_param
